// File: rtl/keypad_scanner_if.sv
// Keypad scanner pin bundle: matrix rows/columns plus the debounced key outputs.
// master = keypad/consumer side, slave = scanner.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (
    output row_in,
    input  col_out, key, key_valid, key_held
  );

  modport slave (
    input  row_in,
    output col_out, key, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with tick-based press/release debounce.
// Reports 4'hF when idle; position row3/col3 is reserved and never reported.
module keypad_scanner #(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic            CLK,
  input  logic            rst,
  keypad_scanner_if.slave bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    PRESSED
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_m_q, row_m_d;
  logic [3:0]    row_s_q, row_s_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  logic          tick;
  logic [3:0]    low;
  logic          hit;
  logic [1:0]    hit_row;
  logic [CW-1:0] cnt_inc;
  logic          cand_low;

  assign tick     = (presc_q == PMAX);
  assign cnt_inc  = cnt_q + 1'b1;
  assign cand_low = ~row_s_q[cand_q];

  // Row 3 in column 3 is the reserved code, so it never counts as a hit.
  always_comb begin
    low = ~row_s_q;
    if (col_q == 2'd3) low[3] = 1'b0;
    hit = |low;
    hit_row = 2'd3;
    if (low[0])      hit_row = 2'd0;
    else if (low[1]) hit_row = 2'd1;
    else if (low[2]) hit_row = 2'd2;
  end

  always_comb begin
    row_m_d = bus.row_in;
    row_s_d = row_m_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = state_q;
    col_d   = col_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    held_d  = held_q;
    valid_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (hit) begin
            cand_d = hit_row;
            if (DEBOUNCE_TICKS == 1) begin
              key_d   = {hit_row, col_q};
              held_d  = 1'b1;
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = PRESSED;
            end else begin
              cnt_d   = CW'(1);
              state_d = PRESS_DB;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        PRESS_DB: begin
          if (hit && hit_row == cand_q) begin
            if (cnt_inc == DMAX) begin
              key_d   = {cand_q, col_q};
              held_d  = 1'b1;
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = PRESSED;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (!cand_low) begin
            if (cnt_inc == DMAX) begin
              key_d   = 4'hF;
              held_d  = 1'b0;
              cnt_d   = '0;
              col_d   = col_q + 2'd1;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      row_m_q <= 4'hF;
      row_s_q <= 4'hF;
      presc_q <= '0;
      state_q <= SCAN;
      col_q   <= 2'd0;
      cand_q  <= 2'd0;
      cnt_q   <= '0;
      key_q   <= 4'hF;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      row_m_q <= row_m_d;
      row_s_q <= row_s_d;
      presc_q <= presc_d;
      state_q <= state_d;
      col_q   <= col_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign bus.col_out   = ~(4'b0001 << col_q);
  assign bus.key       = key_q;
  assign bus.key_valid = valid_q;
  assign bus.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: modelled switch matrix, key_valid scoreboard,
// vector table plus timed bounce/reset sequences.
module tb_keypad_scanner;

  localparam int CLK_DIV = 4;
  localparam int DB      = 3;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;

  keypad_scanner_if bus();

  keypad_scanner #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_TICKS(DB)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Switch matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    bus.row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!bus.col_out[c] && keys[r*4+c]) bus.row_in[r] = 1'b0;
  end

  int         n_chk = 0;
  int         n_fail = 0;
  int         valid_cnt = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    bit          press;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_col(logic [3:0] c, string nm);
    int n;
    n = 0;
    while (bus.col_out == c && n < 50) begin
      step(1);
      n++;
    end
    while (bus.col_out != c && n < 50) begin
      step(1);
      n++;
    end
    chk(nm, n < 50, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.key_valid && n < 200);
  endtask

  task automatic wait_free(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (bus.key !== 4'hF && n < 200);
  endtask

  always @(negedge CLK) begin
    chk("held_vs_key", bus.key_held, bus.key != 4'hF);
    if (bus.key_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0)
        chk("unexpected_valid", exp_q.size(), 1);
      else
        chk("valid_code", bus.key, exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         v0;
    int         changes;
    logic [3:0] prev;
    logic [3:0] cs[5];

    vecs[0] = '{16'h0040, 4'h6, 1'b1};
    vecs[1] = '{16'h0202, 4'h1, 1'b1};
    vecs[2] = '{16'h8000, 4'hF, 1'b0};
    vecs[3] = '{16'h0001, 4'h0, 1'b1};
    vecs[4] = '{16'h4000, 4'hE, 1'b1};
    vecs[5] = '{16'h0800, 4'hB, 1'b1};
    vecs[6] = '{16'h8080, 4'h7, 1'b1};
    vecs[7] = '{16'h1010, 4'h4, 1'b1};
    vecs[8] = '{16'h0008, 4'h3, 1'b1};
    cs[0] = 4'b1110;
    cs[1] = 4'b1101;
    cs[2] = 4'b1011;
    cs[3] = 4'b0111;
    cs[4] = 4'b1110;

    rst = 1'b1;
    step(3);
    chk("rst_col", bus.col_out, 4'b1110);
    chk("rst_key", bus.key, 4'hF);
    chk("rst_valid", bus.key_valid, 0);
    chk("rst_held", bus.key_held, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      step(CLK_DIV - 1);
      chk("col_hold", bus.col_out, cs[i]);
      step(1);
      chk("col_step", bus.col_out, cs[i+1]);
    end

    // Clean press of row1/col2, aligned to the column-2 tick.
    wait_col(4'b1011, "sync_clean");
    v0 = valid_cnt;
    keys = 16'h0040;
    exp_q.push_back(4'h6);
    wait_valid(n);
    chk("press_latency", n, 3 * CLK_DIV);
    chk("press_key", bus.key, 4'h6);
    chk("press_held", bus.key_held, 1);
    step(1);
    chk("valid_single", bus.key_valid, 0);
    step(7);
    chk("key_stable", bus.key, 4'h6);
    keys = '0;
    wait_free(n);
    chk("release_latency", n, 3 * CLK_DIV);
    chk("release_held", bus.key_held, 0);
    chk("release_col", bus.col_out, 4'b0111);
    chk("clean_pulses", valid_cnt - v0, 1);

    // Press bounce: low one tick, high one tick, then low steadily.
    wait_col(4'b1011, "sync_bounce");
    v0 = valid_cnt;
    keys = 16'h0040;
    step(CLK_DIV);
    keys = '0;
    step(CLK_DIV);
    chk("bounce_resume_col", bus.col_out, 4'b0111);
    chk("bounce_no_valid", valid_cnt - v0, 0);
    keys = 16'h0040;
    exp_q.push_back(4'h6);
    wait_valid(n);
    chk("bounce_accept_latency", n, 6 * CLK_DIV);
    step(1);
    chk("bounce_pulses", valid_cnt - v0, 1);
    keys = '0;
    wait_free(n);
    chk("bounce_release_bound", n < 200, 1);

    // Release bounce: high 2 ticks, low 1 tick, then high.
    wait_col(4'b1011, "sync_rbounce");
    v0 = valid_cnt;
    keys = 16'h0040;
    exp_q.push_back(4'h6);
    wait_valid(n);
    chk("rb_press_bound", n < 200, 1);
    keys = '0;
    step(2 * CLK_DIV);
    chk("rb_hold_a", bus.key, 4'h6);
    keys = 16'h0040;
    step(CLK_DIV);
    chk("rb_hold_b", bus.key, 4'h6);
    keys = '0;
    wait_free(n);
    chk("rb_latency", n, 3 * CLK_DIV);
    chk("rb_pulses", valid_cnt - v0, 1);

    // Reset while a key is held.
    keys = 16'h0040;
    exp_q.push_back(4'h6);
    wait_valid(n);
    chk("rh_press_bound", n < 200, 1);
    step(3);
    chk("rh_pre_key", bus.key, 4'h6);
    v0 = valid_cnt;
    rst = 1'b1;
    step(1);
    chk("rh_key", bus.key, 4'hF);
    chk("rh_held", bus.key_held, 0);
    chk("rh_valid", bus.key_valid, 0);
    chk("rh_col", bus.col_out, 4'b1110);
    keys = '0;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rh_no_pulse", valid_cnt - v0, 0);

    for (int i = 0; i < 9; i++) begin
      keys = vecs[i].keys;
      v0 = valid_cnt;
      if (vecs[i].press) begin
        exp_q.push_back(vecs[i].code);
        wait_valid(n);
        chk("vec_press_bound", n < 200, 1);
        chk("vec_key", bus.key, vecs[i].code);
        chk("vec_held", bus.key_held, 1);
        keys = '0;
        wait_free(n);
        chk("vec_release_bound", n < 200, 1);
        step(1);
        chk("vec_pulses", valid_cnt - v0, 1);
      end else begin
        changes = 0;
        prev = bus.col_out;
        repeat (15 * CLK_DIV) begin
          step(1);
          if (bus.col_out != prev) changes++;
          prev = bus.col_out;
        end
        chk("vec_scan_moves", changes, 15);
        chk("vec_none_key", bus.key, 4'hF);
        chk("vec_none_pulses", valid_cnt - v0, 0);
        keys = '0;
      end
    end

    step(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream input stage for the game control unit.
- Scans a 4x4 active-low matrix keypad, debounces presses, and presents a 4-bit key code.
- Output convention: code 0x0..0xE while a key is stably held; 4'hF when no key is pressed.
- Also emits a one-cycle key_valid pulse per accepted press, for consumers that need edge events.

Parameters:
- CLK_DIV, 1000: CLK cycles per scan tick, >=2; the prescaler counts 0..CLK_DIV-1 and a tick fires when it reaches CLK_DIV-1.
- DEBOUNCE_TICKS, 4: consecutive matching ticks required to accept a press or a release, >=1.

Ports:
- CLK  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to CLK
- col_out  output  4  column drive, active-low, exactly one bit low at all times
- key  output  4  current debounced key code; 4'hF = none
- key_valid  output  1  one-CLK pulse when a new press is accepted
- key_held  output  1  high while key holds a valid code

Behaviour:
- Input sync: row_in passes through a 2-flop synchroniser before any use.
- Tick: prescaler increments every CLK and wraps at CLK_DIV-1. All row sampling and FSM decisions happen only on tick cycles.
- Column drive: col_out = ~(4'b0001 << col_idx). The column settles for the whole tick interval before it is sampled.
- Code: code = {row_idx[1:0], col_idx[1:0]}.
  - When several rows are low, the lowest row index wins.
  - Position row3/col3 (code 0xF) is never reported; it is treated as not pressed.
- Reset values: col_idx=0 (col_out=4'b1110), key=4'hF, key_valid=0, key_held=0, prescaler=0, debounce count=0, state=SCAN.
- Reset mid-operation returns everything to the reset values on the next CLK edge, including a held key, which is dropped to 4'hF with no pulse.
- FSM states:
  - SCAN: on each tick, if a valid row is low in col_idx, latch the candidate code, set count=1 and go to PRESS_DB without advancing the column. Otherwise col_idx=col_idx+1, wrapping 3->0.
  - PRESS_DB: column frozen. On a tick where the same row is still the lowest low row, count++. On any mismatch (released, or a different row wins), count=0, col_idx+1, go to SCAN. When count reaches DEBOUNCE_TICKS, go to PRESSED, set key=candidate and key_held=1, and pulse key_valid=1 for that one CLK.
  - PRESSED: column frozen and key held. A tick where the candidate row reads high counts as a release match; count resets on any tick where it reads low. When the release count reaches DEBOUNCE_TICKS, set key=4'hF, key_held=0, col_idx+1, and go to SCAN.
  - A second key pressed in the frozen column while PRESSED is ignored. Keys in other columns are not seen until release.
- Latency: key changes on the CLK edge that ends the DEBOUNCE_TICKS-th matching tick.
  - With DEBOUNCE_TICKS=1 the press is accepted on the detecting tick itself.
- key_valid never asserts twice for one press. It never asserts on release.
- key and key_held always change on the same edge; key_held == (key != 4'hF).

Test Plan:
- Reset: assert rst for 3 CLK with all rows high. Required: col_out=1110, key=F, key_valid=0, key_held=0. After release, col_out steps 1110->1101->1011->0111->1110, one step every CLK_DIV cycles.
- Clean press (CLK_DIV=4, DEBOUNCE_TICKS=3): hold row1 low while col2 is driven. Required: key=0x6, key_held=1 and a single key_valid pulse 2 ticks after detection. key stays 0x6 while held, and returns to F 3 ticks after release.
- Bounce: row1/col2 low for 1 tick, high for 1 tick, then low steadily. Required: no key_valid during the bounce; scanning resumes at col3. Acceptance follows the next clean detection.
- Multi-row and reserved key: rows 0 and 2 low in col1 gives key=0x1. Row3 alone in col3 leaves key=F and scanning continues.
- Release bounce: in PRESSED, row high for 2 ticks, low for 1, then high for 3. Required: key remains 0x6 until the 3rd consecutive high tick, and only one key_valid over the whole sequence.
- Reset while held: assert rst during PRESSED with key=0x6. Required: the next edge gives key=F, key_held=0, key_valid=0, col_out=1110.
